// File: rtl/confreg_sram.sv
// Memory-mapped confreg responder: timer + compare interrupt, LED/scratch registers, console TX FIFO.
// Optional commit-trace registers at 0x1C/0x20 are built when CONFREG_TRACE_EN is defined.
module confreg_sram #(
   parameter logic [15:0] BASE_HI    = 16'hBFAF,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  sel,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        timer_int,
   output logic [15:0] led,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
`ifdef CONFREG_TRACE_EN
   ,
   input  logic [31:0] debug_wb_pc,
   input  logic [0:0]  debug_wb_rf_wen
`endif
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [5:0] IDX_CNT     = 6'h00;
   localparam logic [5:0] IDX_CMP     = 6'h01;
   localparam logic [5:0] IDX_CTRL    = 6'h02;
   localparam logic [5:0] IDX_STATUS  = 6'h03;
   localparam logic [5:0] IDX_TXDATA  = 6'h04;
   localparam logic [5:0] IDX_LED     = 6'h05;
   localparam logic [5:0] IDX_SCRATCH = 6'h06;
`ifdef CONFREG_TRACE_EN
   localparam logic [5:0] IDX_TPC     = 6'h07;
   localparam logic [5:0] IDX_TCNT    = 6'h08;
`endif

   // Byte-enable merge of new data over an existing register value
   function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

   logic [31:0] cnt_q, cnt_d;
   logic [31:0] cmp_q, cmp_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic        pend_q, pend_d;
   logic        ovf_q, ovf_d;
   logic [15:0] led_q, led_d;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] rdata_q, rdata_d;
   logic        timer_int_q, timer_int_d;
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [7:0]  mem_d [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
`ifdef CONFREG_TRACE_EN
   logic [31:0] trace_pc_q, trace_pc_d;
   logic [31:0] trace_cnt_q, trace_cnt_d;
`endif

   logic        hit, wr, rd_any;
   logic [5:0]  idx;
   logic        full, empty, push_req, push_acc, pop;
   logic [31:0] status;
   logic [31:0] rmux;
   logic        unused_addr_c;

   assign unused_addr_c = ^{addr[15:8], addr[1:0]};

   always_comb begin
      cnt_d       = cnt_q;
      cmp_d       = cmp_q;
      ctrl_d      = ctrl_q;
      pend_d      = pend_q;
      ovf_d       = ovf_q;
      led_d       = led_q;
      scratch_d   = scratch_q;
      rdata_d     = rdata_q;
      mem_d       = mem_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      timer_int_d = pend_q & ctrl_q[1];
`ifdef CONFREG_TRACE_EN
      trace_pc_d  = trace_pc_q;
      trace_cnt_d = trace_cnt_q;
`endif

      hit    = en && (addr[31:16] == BASE_HI);
      wr     = hit && (sel != 4'b0000);
      rd_any = en && (sel == 4'b0000);
      idx    = addr[7:2];

      full   = (count_q == CW'(FIFO_DEPTH));
      empty  = (count_q == '0);
      status = {16'h0000, 8'(count_q), 4'h0, ovf_q, empty, full, pend_q};

      // A CNT write takes precedence; unwritten bytes hold rather than increment
      if (wr && idx == IDX_CNT) cnt_d = merge_be(cnt_q, wdata, sel);
      else if (ctrl_q[0])      cnt_d = cnt_q + 32'd1;

      if (wr && idx == IDX_CMP)                cmp_d     = merge_be(cmp_q, wdata, sel);
      if (wr && idx == IDX_CTRL && sel[0])     ctrl_d    = wdata[1:0];
      if (wr && idx == IDX_SCRATCH)            scratch_d = merge_be(scratch_q, wdata, sel);
      if (wr && idx == IDX_LED) begin
         if (sel[0]) led_d[7:0]  = wdata[7:0];
         if (sel[1]) led_d[15:8] = wdata[15:8];
      end

      // W1C first so a same-cycle set wins
      if (wr && idx == IDX_STATUS && sel[0] && wdata[0]) pend_d = 1'b0;
      if (wr && idx == IDX_STATUS && sel[0] && wdata[3]) ovf_d  = 1'b0;
      if (ctrl_q[0] && (cnt_q == cmp_q))                  pend_d = 1'b1;

      pop      = tx_valid_q && tx_ready;
      push_req = wr && (idx == IDX_TXDATA) && sel[0];
      push_acc = push_req && (!full || pop);
      if (push_req && full && !pop) ovf_d = 1'b1;

      if (push_acc) begin
         mem_d[wptr_q] = wdata[7:0];
         wptr_d        = wptr_q + PW'(1);
      end
      if (pop) rptr_d = rptr_q + PW'(1);
      count_d = count_q + (push_acc ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));

      // Head byte is registered; bypass the incoming byte when it lands at the new head
      tx_data_d  = (push_acc && (wptr_q == rptr_d)) ? wdata[7:0] : mem_q[rptr_d];
      tx_valid_d = (count_d != '0);

`ifdef CONFREG_TRACE_EN
      if (debug_wb_rf_wen[0]) begin
         trace_pc_d  = debug_wb_pc;
         trace_cnt_d = trace_cnt_q + 32'd1;
      end
`endif

      case (idx)
         IDX_CNT:     rmux = cnt_q;
         IDX_CMP:     rmux = cmp_q;
         IDX_CTRL:    rmux = {30'd0, ctrl_q};
         IDX_STATUS:  rmux = status;
         IDX_TXDATA:  rmux = 32'(count_q);
         IDX_LED:     rmux = {16'h0000, led_q};
         IDX_SCRATCH: rmux = scratch_q;
`ifdef CONFREG_TRACE_EN
         IDX_TPC:     rmux = trace_pc_q;
         IDX_TCNT:    rmux = trace_cnt_q;
`endif
         default:     rmux = 32'd0;
      endcase

      if (rd_any) rdata_d = hit ? rmux : 32'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         cmp_q       <= '0;
         ctrl_q      <= '0;
         pend_q      <= 1'b0;
         ovf_q       <= 1'b0;
         led_q       <= '0;
         scratch_q   <= '0;
         rdata_q     <= '0;
         timer_int_q <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
`ifdef CONFREG_TRACE_EN
         trace_pc_q  <= '0;
         trace_cnt_q <= '0;
`endif
      end else begin
         cnt_q       <= cnt_d;
         cmp_q       <= cmp_d;
         ctrl_q      <= ctrl_d;
         pend_q      <= pend_d;
         ovf_q       <= ovf_d;
         led_q       <= led_d;
         scratch_q   <= scratch_d;
         rdata_q     <= rdata_d;
         timer_int_q <= timer_int_d;
         mem_q       <= mem_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
`ifdef CONFREG_TRACE_EN
         trace_pc_q  <= trace_pc_d;
         trace_cnt_q <= trace_cnt_d;
`endif
      end
   end

   assign rdata     = rdata_q;
   assign timer_int = timer_int_q;
   assign led       = led_q;
   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_confreg_sram.sv
// Directed bench for confreg_sram: register table, timer compare, FIFO fill/drain/overflow, reset.
module tb_confreg_sram;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  sel;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        timer_int;
   logic [15:0] led;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] B = 32'hBFAF_0000;

   confreg_sram dut (
      .clk(clk), .rst(rst), .en(en), .sel(sel), .addr(addr), .wdata(wdata),
      .rdata(rdata), .timer_int(timer_int), .led(led),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [3:0]  s;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic [15:0] exp_led;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // All bus tasks start and end at a falling edge
   task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      en = 1'b1; sel = s; addr = a; wdata = d;
      @(negedge clk);
      en = 1'b0; sel = 4'b0000;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] r);
      en = 1'b1; sel = 4'b0000; addr = a;
      @(negedge clk);
      en = 1'b0;
      r = rdata;
   endtask

   task automatic wait_int(output int n);
      n = 0;
      while (!timer_int && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   logic [31:0] r;
   int          n;

   initial begin
      rst = 1'b1; en = 1'b0; sel = '0; addr = '0; wdata = '0; tx_ready = 1'b0;
      #1;
      check("rst_rdata", rdata, 32'h0);
      check("rst_timer_int", {31'd0, timer_int}, 32'h0);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
      check("rst_led", {16'd0, led}, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reads use sel=0 (exp_rd checked); writes use sel!=0 (only led checked)
      vq.push_back('{B + 32'h00, 4'h0, 32'h0,        32'h0000_0000, 16'h0000});
      vq.push_back('{B + 32'h04, 4'h0, 32'h0,        32'h0000_0000, 16'h0000});
      vq.push_back('{B + 32'h08, 4'h0, 32'h0,        32'h0000_0000, 16'h0000});
      vq.push_back('{B + 32'h0C, 4'h0, 32'h0,        32'h0000_0004, 16'h0000});
      vq.push_back('{B + 32'h10, 4'h0, 32'h0,        32'h0000_0000, 16'h0000});
      vq.push_back('{B + 32'h14, 4'h0, 32'h0,        32'h0000_0000, 16'h0000});
      vq.push_back('{B + 32'h18, 4'h0, 32'h0,        32'h0000_0000, 16'h0000});
      vq.push_back('{B + 32'h14, 4'h2, 32'hAABBCCDD, 32'h0,         16'hCC00});
      vq.push_back('{B + 32'h14, 4'h1, 32'h00000012, 32'h0,         16'hCC12});
      vq.push_back('{B + 32'h14, 4'h0, 32'h0,        32'h0000_CC12, 16'hCC12});
      vq.push_back('{B + 32'h18, 4'hF, 32'hDEADBEEF, 32'h0,         16'hCC12});
      vq.push_back('{B + 32'h18, 4'h4, 32'h00550000, 32'h0,         16'hCC12});
      vq.push_back('{B + 32'h18, 4'h0, 32'h0,        32'hDE55_BEEF, 16'hCC12});
      vq.push_back('{32'hBFB00000, 4'h0, 32'h0,      32'h0000_0000, 16'hCC12});
      vq.push_back('{B + 32'h18, 4'h0, 32'h0,        32'hDE55_BEEF, 16'hCC12});
      vq.push_back('{B + 32'h3C, 4'h0, 32'h0,        32'h0000_0000, 16'hCC12});
      vq.push_back('{32'hBFB00018, 4'hF, 32'h11111111, 32'h0,       16'hCC12});
      vq.push_back('{B + 32'h3C, 4'hF, 32'h22222222, 32'h0,         16'hCC12});
      vq.push_back('{32'hBFB00014, 4'hF, 32'h0000FFFF, 32'h0,       16'hCC12});
      vq.push_back('{B + 32'h18, 4'h0, 32'h0,        32'hDE55_BEEF, 16'hCC12});
      vq.push_back('{B + 32'h14, 4'h0, 32'h0,        32'h0000_CC12, 16'hCC12});
      vq.push_back('{B + 32'h04, 4'hF, 32'h12345678, 32'h0,         16'hCC12});
      vq.push_back('{B + 32'h04, 4'h0, 32'h0,        32'h1234_5678, 16'hCC12});
      vq.push_back('{B + 32'h08, 4'hF, 32'hFFFFFFFE, 32'h0,         16'hCC12});
      vq.push_back('{B + 32'h08, 4'h0, 32'h0,        32'h0000_0002, 16'hCC12});
      vq.push_back('{B + 32'h08, 4'hF, 32'h00000000, 32'h0,         16'hCC12});
      vq.push_back('{B + 32'h1C, 4'h0, 32'h0,        32'h0000_0000, 16'hCC12});
      vq.push_back('{B + 32'h00, 4'h0, 32'h0,        32'h0000_0000, 16'hCC12});
      vq.push_back('{B + 32'h20, 4'h0, 32'h0,        32'h0000_0000, 16'hCC12});

      foreach (vq[i]) begin
         if (vq[i].s == 4'h0) begin
            rd(vq[i].a, r);
            check($sformatf("vec%0d_rdata", i), r, vq[i].exp_rd);
         end else begin
            wr(vq[i].a, vq[i].s, vq[i].d);
         end
         check($sformatf("vec%0d_led", i), {16'd0, led}, {16'd0, vq[i].exp_led});
      end

      // Timer compare: CNT runs 0x10 -> 0x20, pend one edge later, timer_int the next
      wr(B + 32'h04, 4'hF, 32'h20);
      wr(B + 32'h00, 4'hF, 32'h10);
      wr(B + 32'h08, 4'hF, 32'h3);
      wait_int(n);
      check("timer_first_rise_cycles", 32'(n), 32'd18);
      rd(B + 32'h0C, r);
      check("status_pend", r, 32'h5);
      wr(B + 32'h0C, 4'hF, 32'h1);
      @(negedge clk);
      check("timer_int_cleared", {31'd0, timer_int}, 32'h0);
      wr(B + 32'h00, 4'hF, 32'hFFFF_FFF0);
      wait_int(n);
      check("timer_rise_after_wrap", 32'(n), 32'd50);

      // Set and W1C in the same cycle: set wins
      wr(B + 32'h08, 4'hF, 32'h1);
      wr(B + 32'h04, 4'hF, 32'h100);
      wr(B + 32'h0C, 4'hF, 32'h1);
      wr(B + 32'h00, 4'hF, 32'h100);
      wr(B + 32'h0C, 4'hF, 32'h1);
      rd(B + 32'h0C, r);
      check("set_beats_w1c", r, 32'h5);
      wr(B + 32'h0C, 4'hF, 32'h1);
      rd(B + 32'h0C, r);
      check("plain_w1c", r, 32'h4);
      check("int_masked", {31'd0, timer_int}, 32'h0);
      wr(B + 32'h08, 4'hF, 32'h0);

      // FIFO fill and overflow
      for (int i = 0; i < 8; i++) wr(B + 32'h10, 4'h1, 32'h41 + 32'(i));
      rd(B + 32'h0C, r);
      check("fifo_full_status", r, 32'h0000_0802);
      rd(B + 32'h10, r);
      check("fifo_count_txdata", r, 32'd8);
      wr(B + 32'h10, 4'h1, 32'h49);
      rd(B + 32'h0C, r);
      check("fifo_overflow_status", r, 32'h0000_080A);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_valid%0d", i), {31'd0, tx_valid}, 32'h1);
         check($sformatf("drain_data%0d", i), {24'd0, tx_data}, 32'h41 + 32'(i));
         @(negedge clk);
      end
      check("drain_done_valid", {31'd0, tx_valid}, 32'h0);
      tx_ready = 1'b0;
      rd(B + 32'h0C, r);
      check("drain_empty_status", r, 32'h0000_000C);
      wr(B + 32'h0C, 4'hF, 32'h8);
      rd(B + 32'h0C, r);
      check("ovf_w1c", r, 32'h4);

      // Push and pop together while full
      for (int i = 0; i < 8; i++) wr(B + 32'h10, 4'h1, 32'h50 + 32'(i));
      tx_ready = 1'b1;
      wr(B + 32'h10, 4'h1, 32'h58);
      tx_ready = 1'b0;
      rd(B + 32'h0C, r);
      check("full_pushpop_status", r, 32'h0000_0802);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("pp_data%0d", i), {24'd0, tx_data}, 32'h51 + 32'(i));
         @(negedge clk);
      end
      check("pp_done_valid", {31'd0, tx_valid}, 32'h0);

      // Push with tx_ready high while empty: nothing pops that cycle
      wr(B + 32'h10, 4'h1, 32'h60);
      check("empty_push_valid", {31'd0, tx_valid}, 32'h1);
      check("empty_push_data", {24'd0, tx_data}, 32'h60);
      @(negedge clk);
      check("empty_push_popped", {31'd0, tx_valid}, 32'h0);
      tx_ready = 1'b0;

      // Reset in the middle of a drain
      wr(B + 32'h10, 4'h1, 32'h70);
      wr(B + 32'h10, 4'h1, 32'h71);
      wr(B + 32'h10, 4'h1, 32'h72);
      tx_ready = 1'b1;
      @(negedge clk);
      check("pre_rst_head", {24'd0, tx_data}, 32'h71);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", {31'd0, tx_valid}, 32'h0);
      check("mid_rst_data", {24'd0, tx_data}, 32'h0);
      check("mid_rst_led", {16'd0, led}, 32'h0);
      tx_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rd(B + 32'h0C, r);
      check("post_rst_status", r, 32'h4);
      rd(B + 32'h18, r);
      check("post_rst_scratch", r, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/confreg_sram.md
Name: confreg_sram

Overview:
- Memory-mapped configuration/peripheral responder on the core's data SRAM-like port, alongside data_sram. It is the slave end of the same en/sel/addr/wdata/rdata protocol.
- Provides:
  - a 32-bit timer with compare interrupt, driven into one bit of the core's 6-bit interrupt input;
  - an LED register and a scratch register;
  - a byte console TX FIFO drained through a valid/ready handshake.
- Read timing matches data_sram: registered read data, one-cycle latency.

Parameters:
- BASE_HI, 16'hBFAF, required value of addr[31:16]; any other value is a miss.
- FIFO_DEPTH, 8, console FIFO depth in bytes; power of two, 2..64.

Ports:
- clk  in  1  clock (cpu_clk domain).
- rst  in  1  asynchronous reset, active-high.
- en  in  1  access strobe from the core.
- sel  in  4  byte enables; nonzero = write, zero = read.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- timer_int  out  1  timer interrupt level.
- led  out  16  LED register.
- tx_data  out  8  console byte at the FIFO head.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts the head byte this cycle.

Behaviour:
- Reset (async, rst=1): all of the following clear to 0 immediately: rdata, timer_int, led, tx_valid, tx_data, CNT, CMP, CTRL, STATUS, SCRATCH, FIFO pointers and count. Reset in the middle of a FIFO drain discards all buffered bytes.
- Hit: en && addr[31:16]==BASE_HI. Register index = addr[7:2]. addr[1:0] are ignored.
- Write: hit && sel!=0. Each register byte is updated only where its sel bit is set.
- Read: hit && sel==0. rdata is loaded at the next clk edge with the register's pre-edge value.
  - rdata holds its value when there is no read.
  - A miss or an unmapped index loads 0 and causes no side effects.
- Register map:
  - 0x00 CNT (RW):
    - increments by 1 every cycle while CTRL[0]=1;
    - wraps 0xFFFFFFFF to 0;
    - a write wins over the increment; unwritten bytes keep their current value, not the incremented one.
  - 0x04 CMP (RW).
  - 0x08 CTRL (RW) [1:0]:
    - bit0 = timer enable;
    - bit1 = interrupt enable;
    - other bits read 0.
  - 0x0C STATUS:
    - bit0 timer_pend (W1C);
    - bit1 fifo_full (RO);
    - bit2 fifo_empty (RO);
    - bit3 tx_overflow (W1C, sticky);
    - [15:8] fifo count (RO).
  - 0x10 TXDATA:
    - a write with sel[0]=1 pushes wdata[7:0] into the FIFO;
    - a read returns the FIFO count.
  - 0x14 LED (RW) [15:0]; the led port is driven directly from this register.
  - 0x18 SCRATCH (RW) 32 bits.
- Timer compare:
  - When CTRL[0]=1 and CNT==CMP, timer_pend is set at the next edge.
  - If a set and a W1C of timer_pend occur in the same cycle, the set wins.
- timer_int = timer_pend & CTRL[1], registered. It is a level: it stays high until software clears the pending bit.
- FIFO:
  - tx_data is the head entry. tx_valid = count != 0.
  - Pop: tx_valid && tx_ready, at the clock edge.
  - Push when count==FIFO_DEPTH and no pop in the same cycle: the byte is dropped and tx_overflow is set.
  - Push and pop in the same cycle while full: both happen and the count is unchanged.
  - Push and pop in the same cycle while empty: no pop, since tx_valid=0.
  - Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
- Macro: CONFREG_TRACE_EN.
- Defined:
  - Adds inputs debug_wb_pc[31:0] and debug_wb_rf_wen[0:0] from the core's commit trace.
  - 0x1C TRACE_PC (RO) holds the last debug_wb_pc seen with wen=1.
  - 0x20 TRACE_CNT (RO) is a wrapping 32-bit count of cycles with wen=1.
  - Both registers reset to 0.
- Undefined: those ports do not exist, and 0x1C/0x20 are unmapped and read 0.

Test Plan:
- Reset: after rst is released, reading each index 0x00..0x18 returns 0, except STATUS, which returns 0x00000004. timer_int=0, tx_valid=0, led=0.
- Timer compare:
  - Stimulus: write CMP=0x20, then CNT=0x10, then CTRL=0x3.
  - timer_int rises within two cycles of CNT reaching 0x20, and STATUS bit0 reads 1.
  - Writing STATUS=0x1 drops timer_int; it rises again only after CNT wraps back to 0x20.
- Byte-enabled LED write:
  - Write LED with sel=4'b0010, wdata=0xAABBCCDD: led=0xCC00.
  - Then write with sel=4'b0001, wdata=0x12: led=0xCC12.
- FIFO fill and overflow (FIFO_DEPTH=8, tx_ready=0):
  - Push 0x41..0x49 (9 bytes): after 8 pushes STATUS[1]=1 and the count is 8; the 9th byte is dropped and STATUS[3]=1.
  - Raise tx_ready: 0x41..0x48 leave in order over 8 cycles, then tx_valid=0 and STATUS[2]=1.
- Simultaneous events:
  - A W1C of STATUS bit0 in the same cycle as CNT==CMP leaves timer_pend=1.
  - With the FIFO full, a push together with a pop keeps the count at 8, and the new byte exits last.
- Miss and unmapped accesses:
  - A read at addr 0xBFB00000, or at index 0x3C, returns rdata=0.
  - A write to either address changes no register.
